// File: rtl/acc_pkg.sv
// Shared accumulator-path widths and the requantisation helpers used by the
// bias, activation and pooling stages.
package acc_pkg;

  localparam int AB_BW  = 21;
  localparam int A_BW   = 8;
  localparam int SH_BW  = 4;
  localparam int CNT_BW = 10;

  localparam logic [A_BW-1:0] ACT_MAX = '1;

  // ReLU followed by round-half-up right shift; one extra bit keeps the add from wrapping.
  function automatic logic [AB_BW:0] relu_round_shift(input logic [AB_BW-1:0] x,
                                                      input logic [SH_BW-1:0] sh);
    logic [AB_BW:0] ext;
    logic [AB_BW:0] rnd;
    logic [AB_BW:0] one;
    one = {{AB_BW{1'b0}}, 1'b1};
    ext = {1'b0, x};
    rnd = (sh == '0) ? '0 : (one << (sh - 1'b1));
    if (x[AB_BW-1]) begin
      return '0;
    end
    return (ext + rnd) >> sh;
  endfunction

  function automatic logic [A_BW-1:0] sat_act(input logic [AB_BW:0] r);
    return (|r[AB_BW:A_BW]) ? ACT_MAX : r[A_BW-1:0];
  endfunction

endpackage

// File: rtl/act_quant_lane.sv
// One activation lane: ReLU + rounding shift on the input side, unsigned
// saturation on the registered side of the pipeline.
module act_quant_lane
  import acc_pkg::*;
(
  input  logic [AB_BW-1:0] i_x,
  input  logic [SH_BW-1:0] i_shift,
  output logic [AB_BW:0]   o_r,
  input  logic [AB_BW:0]   i_r,
  output logic [A_BW-1:0]  o_act
);

  assign o_r   = relu_round_shift(i_x, i_shift);
  assign o_act = sat_act(i_r);

endmodule

// File: rtl/act_quant.sv
// Three-lane activation requantiser: 2-stage valid/ready pipeline with a
// per-frame beat counter that marks the final beat with o_last.
module act_quant
  import acc_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_clear,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [AB_BW-1:0]  i_acc_bias0,
  input  logic [AB_BW-1:0]  i_acc_bias1,
  input  logic [AB_BW-1:0]  i_acc_bias2,
  input  logic [SH_BW-1:0]  i_shift,
  input  logic [CNT_BW-1:0] i_num_out,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [A_BW-1:0]   o_act0,
  output logic [A_BW-1:0]   o_act1,
  output logic [A_BW-1:0]   o_act2,
  output logic              o_last
);

  localparam int LANES = 3;

  logic [AB_BW-1:0]  acc_in   [LANES];
  logic [AB_BW:0]    r_next   [LANES];
  logic [AB_BW:0]    s1_r_reg [LANES];
  logic [A_BW-1:0]   act_next [LANES];
  logic [A_BW-1:0]   act_reg  [LANES];

  logic              s1_valid_reg;
  logic              o_valid_reg;
  logic              o_last_reg;
  logic [CNT_BW-1:0] cnt_reg;
  logic [CNT_BW-1:0] cnt_next;
  logic [CNT_BW-1:0] lim_m1;
  logic              last_next;
  logic              adv;

  assign acc_in[0] = i_acc_bias0;
  assign acc_in[1] = i_acc_bias1;
  assign acc_in[2] = i_acc_bias2;

  // Whole pipeline moves together; only a held output beat can stall it.
  assign adv     = !o_valid_reg || i_ready;
  assign o_ready = adv;

  // A frame length of 0 behaves as 1, so every beat is last.
  always_comb begin
    lim_m1    = (i_num_out == '0) ? '0 : i_num_out - 1'b1;
    last_next = (cnt_reg == lim_m1);
    cnt_next  = last_next ? '0 : cnt_reg + 1'b1;
  end

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      act_quant_lane u_lane (
        .i_x     (acc_in[gi]),
        .i_shift (i_shift),
        .o_r     (r_next[gi]),
        .i_r     (s1_r_reg[gi]),
        .o_act   (act_next[gi])
      );

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          s1_r_reg[gi] <= '0;
          act_reg[gi]  <= '0;
        end else if (adv) begin
          if (i_valid) begin
            s1_r_reg[gi] <= r_next[gi];
          end
          if (s1_valid_reg) begin
            act_reg[gi] <= act_next[gi];
          end
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_reg <= 1'b0;
      o_valid_reg  <= 1'b0;
      o_last_reg   <= 1'b0;
      cnt_reg      <= '0;
    end else if (i_clear) begin
      s1_valid_reg <= 1'b0;
      o_valid_reg  <= 1'b0;
      o_last_reg   <= 1'b0;
      cnt_reg      <= '0;
    end else if (adv) begin
      s1_valid_reg <= i_valid;
      o_valid_reg  <= s1_valid_reg;
      o_last_reg   <= s1_valid_reg && last_next;
      if (s1_valid_reg) begin
        cnt_reg <= cnt_next;
      end
    end
  end

  assign o_valid = o_valid_reg;
  assign o_last  = o_last_reg;
  assign o_act0  = act_reg[0];
  assign o_act1  = act_reg[1];
  assign o_act2  = act_reg[2];

endmodule

// File: tb/tb_act_quant.sv
// Randomised bench for act_quant against an arithmetic reference model with
// an in-order expected-beat queue and a frame counter.
module tb_act_quant;

  logic        clk;
  logic        rst_n;
  logic        i_clear;
  logic        i_valid;
  logic        o_ready;
  logic [20:0] i_acc_bias0;
  logic [20:0] i_acc_bias1;
  logic [20:0] i_acc_bias2;
  logic [3:0]  i_shift;
  logic [9:0]  i_num_out;
  logic        o_valid;
  logic        i_ready;
  logic [7:0]  o_act0;
  logic [7:0]  o_act1;
  logic [7:0]  o_act2;
  logic        o_last;

  act_quant dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_clear     (i_clear),
    .i_valid     (i_valid),
    .o_ready     (o_ready),
    .i_acc_bias0 (i_acc_bias0),
    .i_acc_bias1 (i_acc_bias1),
    .i_acc_bias2 (i_acc_bias2),
    .i_shift     (i_shift),
    .i_num_out   (i_num_out),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_act0      (o_act0),
    .o_act1      (o_act1),
    .o_act2      (o_act2),
    .o_last      (o_last)
  );

  typedef struct {
    int a0;
    int a1;
    int a2;
  } beat_t;

  beat_t      exp_q[$];
  int         errors = 0;
  int         checks = 0;
  int         mcnt = 0;
  int         lasts_seen = 0;
  int         delivered = 0;
  int         xin[3];
  bit         prev_stall = 0;
  logic [7:0] pa0, pa1, pa2;
  logic       pl;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm, input longint act, input longint expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, expv);
    end
  endtask

  // ReLU, add half an LSB of the result, divide by 2^sh, clip to 255.
  function automatic int model_act(input int x, input int sh);
    longint r;
    if (x < 0) return 0;
    r = x;
    if (sh > 0) r = r + (longint'(1) << (sh - 1));
    r = r / (longint'(1) << sh);
    return (r > 255) ? 255 : int'(r);
  endfunction

  function automatic int rand_x();
    case ($urandom_range(0, 4))
      0:       return -int'($urandom_range(1, 1048576));
      1:       return int'($urandom_range(0, 300));
      2:       return int'($urandom_range(0, 1048575));
      3:       return 1048575;
      default: return int'($urandom_range(900, 1100));
    endcase
  endfunction

  task automatic drive(input bit v, input bit rdy, input bit clr,
                       input int x0, input int x1, input int x2, input int sh);
    i_valid     = v;
    i_ready     = rdy;
    i_clear     = clr;
    xin[0]      = x0;
    xin[1]      = x1;
    xin[2]      = x2;
    i_acc_bias0 = 21'(x0);
    i_acc_bias1 = 21'(x1);
    i_acc_bias2 = 21'(x2);
    i_shift     = 4'(sh);
  endtask

  task automatic rand_drive(input bit v, input bit rdy, input bit clr);
    drive(v, rdy, clr, rand_x(), rand_x(), rand_x(), int'($urandom_range(0, 15)));
  endtask

  // Called just after a falling edge with inputs set; checks outputs and
  // books the beat moving at the coming rising edge.
  task automatic step();
    beat_t e;
    int    lim;
    bit    exp_last;
    #1;
    chk("o_ready", o_ready, (!o_valid || i_ready));
    if (prev_stall) begin
      chk("stall_valid", o_valid, 1);
      chk("stall_act0", o_act0, pa0);
      chk("stall_act1", o_act1, pa1);
      chk("stall_act2", o_act2, pa2);
      chk("stall_last", o_last, pl);
    end
    if (!o_valid) chk("idle_last", o_last, 0);
    if (o_valid && i_ready) begin
      chk("beat_pending", (exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        e        = exp_q.pop_front();
        lim      = (i_num_out == 0) ? 1 : int'(i_num_out);
        exp_last = (mcnt == lim - 1);
        mcnt     = exp_last ? 0 : mcnt + 1;
        chk("act0", o_act0, e.a0);
        chk("act1", o_act1, e.a1);
        chk("act2", o_act2, e.a2);
        chk("last", o_last, exp_last);
        delivered++;
        if (o_last) lasts_seen++;
      end
    end
    if (i_clear) begin
      exp_q.delete();
      mcnt = 0;
    end else if (i_valid && o_ready) begin
      e.a0 = model_act(xin[0], int'(i_shift));
      e.a1 = model_act(xin[1], int'(i_shift));
      e.a2 = model_act(xin[2], int'(i_shift));
      exp_q.push_back(e);
    end
    prev_stall = o_valid && !i_ready && !i_clear;
    pa0 = o_act0;
    pa1 = o_act1;
    pa2 = o_act2;
    pl  = o_last;
    @(negedge clk);
  endtask

  task automatic drain();
    int n;
    n = 0;
    drive(0, 1, 0, 0, 0, 0, 0);
    while ((exp_q.size() != 0 || o_valid) && n < 50) begin
      step();
      n++;
    end
    chk("drain_empty", exp_q.size(), 0);
  endtask

  task automatic do_clear();
    drive(0, 1, 1, 0, 0, 0, 0);
    step();
  endtask

  initial begin
    rst_n     = 1'b0;
    i_num_out = 10'd4;
    drive(0, 1, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    #1;
    chk("rst_valid", o_valid, 0);
    chk("rst_act0", o_act0, 0);
    chk("rst_act2", o_act2, 0);
    chk("rst_last", o_last, 0);
    chk("rst_ready", o_ready, 1);
    rst_n = 1'b1;
    @(negedge clk);

    // Hand-computed values pinning the reference model.
    chk("model_1000_s2", model_act(1000, 2), 250);
    chk("model_neg5_s2", model_act(-5, 2), 0);
    chk("model_6_s2", model_act(6, 2), 2);
    chk("model_1023_s2", model_act(1023, 2), 255);
    chk("model_77_s0", model_act(77, 0), 77);
    chk("model_5_s1", model_act(5, 1), 3);
    chk("model_max_s0", model_act(1048575, 0), 255);

    // Single beat, two-cycle latency.
    drive(1, 1, 0, 1000, -5, 6, 2);
    step();
    drive(0, 1, 0, 0, 0, 0, 0);
    step();
    #1;
    chk("lat_valid", o_valid, 1);
    chk("lat_act0", o_act0, 250);
    chk("lat_act1", o_act1, 0);
    chk("lat_act2", o_act2, 2);
    step();
    drain();

    // Saturation and rounding corners.
    drive(1, 1, 0, 1023, 77, 5, 2);       step();
    drive(1, 1, 0, 77, 1048575, -1, 0);   step();
    drive(1, 1, 0, 5, 1023, 0, 1);        step();
    drive(1, 1, 0, 1048575, 6, 255, 0);   step();
    drain();

    // Framing: 4-beat frames, then length 0 meaning every beat is last.
    do_clear();
    i_num_out  = 10'd4;
    lasts_seen = 0;
    for (int i = 0; i < 10; i++) begin
      rand_drive(1, 1, 0);
      step();
    end
    drain();
    chk("frame4_lasts", lasts_seen, 2);
    do_clear();
    i_num_out  = 10'd0;
    lasts_seen = 0;
    for (int i = 0; i < 5; i++) begin
      rand_drive(1, 1, 0);
      step();
    end
    drain();
    chk("frame0_lasts", lasts_seen, 5);

    // Backpressure: 6 beats, downstream not ready on cycles 3-5.
    do_clear();
    i_num_out = 10'd8;
    begin
      int sent;
      int d0;
      sent = 0;
      d0   = delivered;
      for (int c = 0; c < 14; c++) begin
        rand_drive(sent < 6, !(c >= 3 && c <= 5), 0);
        if (i_valid) begin
          #1;
          if (o_ready) sent++;
          #0;
        end
        step();
      end
      drain();
      chk("bp_delivered", delivered - d0, 6);
    end

    // Clear with two beats in flight; next beat starts a new frame.
    do_clear();
    i_num_out = 10'd2;
    rand_drive(1, 1, 0); step();
    drain();
    rand_drive(1, 1, 0); step();
    rand_drive(1, 0, 0); step();
    rand_drive(1, 0, 1); step();
    #1;
    chk("clr_valid", o_valid, 0);
    lasts_seen = 0;
    rand_drive(1, 1, 0); step();
    rand_drive(1, 1, 0); step();
    drain();
    chk("clr_new_frame_lasts", lasts_seen, 1);

    // Long randomised run with occasional clears.
    do_clear();
    i_num_out = 10'($urandom_range(1, 7));
    for (int c = 0; c < 400; c++) begin
      rand_drive($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7, $urandom_range(0, 49) == 0);
      step();
    end
    drain();

    // Asynchronous reset between clock edges in the middle of a stream.
    do_clear();
    i_num_out = 10'd3;
    for (int c = 0; c < 5; c++) begin
      rand_drive(1, $urandom_range(0, 1), 0);
      step();
    end
    rand_drive(1, 1, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", o_valid, 0);
    chk("arst_act0", o_act0, 0);
    chk("arst_act1", o_act1, 0);
    chk("arst_last", o_last, 0);
    exp_q.delete();
    mcnt       = 0;
    prev_stall = 0;
    i_valid    = 1'b0;
    @(negedge clk);
    rst_n      = 1'b1;
    lasts_seen = 0;
    for (int c = 0; c < 7; c++) begin
      rand_drive(1, 1, 0);
      step();
    end
    drain();
    chk("arst_resume_lasts", lasts_seen, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
